// File: rtl/ula_resultado_bcd.sv
// ULA result stage: captures one ALU result and converts it to packed BCD
// with a bit-serial shift-add-3 engine, holding the digits for the display.
module ula_resultado_bcd #(
  parameter int         DATA_W = 8,
  parameter int         NDIG   = 3,
  parameter logic [2:0] SUB_OP = 3'b001
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   resultado,
  input  logic                carry,
  input  logic [2:0]          opcode,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd,
  output logic                negativo,
  output logic                carry_q
);

  localparam int SR_W  = 4*NDIG + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SR_W-1:0]   sreg;
  logic [SR_W-1:0]   sreg_adj;
  logic [SR_W-1:0]   sreg_step;
  logic [CNT_W-1:0]  count;
  logic              neg_q;
  logic              cy_q;
  logic              neg_in;
  logic [DATA_W-1:0] mag;
  logic              accept;
  logic              last_shift;

  assign accept     = (state == IDLE) && start;
  assign last_shift = (state == SHIFT) &&
                      (count == CNT_W'(DATA_W - 1));

  // Subtraction results with the MSB set are shown as a negative magnitude
  always_comb begin
    neg_in = (opcode == SUB_OP) && resultado[DATA_W-1];
    mag    = resultado;
    if (neg_in)
      mag = ~resultado + DATA_W'(1);
  end

  // Digits only, never the binary tail; no carry crosses a digit boundary
  always_comb begin
    sreg_adj = sreg;
    for (int d = 0; d < NDIG; d++) begin
      if (sreg[DATA_W+4*d +: 4] >= 4'd5)
        sreg_adj[DATA_W+4*d +: 4] = sreg[DATA_W+4*d +: 4] + 4'd3;
    end
    sreg_step = sreg_adj << 1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)      state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state)
      IDLE:  ready = 1'b1;
      SHIFT: busy  = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Held outputs move only when a conversion finishes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg     <= '0;
      count    <= '0;
      neg_q    <= 1'b0;
      cy_q     <= 1'b0;
      bcd      <= '0;
      negativo <= 1'b0;
      carry_q  <= 1'b0;
    end else if (accept) begin
      sreg  <= {{(4*NDIG){1'b0}}, mag};
      count <= '0;
      neg_q <= neg_in;
      cy_q  <= carry;
    end else if (state == SHIFT) begin
      sreg  <= sreg_step;
      count <= count + CNT_W'(1);
      if (last_shift) begin
        bcd      <= sreg_step[SR_W-1:DATA_W];
        negativo <= neg_q;
        carry_q  <= cy_q;
      end
    end
  end

endmodule

// File: tb/tb_ula_resultado_bcd.sv
// Bench for ula_resultado_bcd: directed scenarios plus random results
// checked against a decimal-arithmetic reference model.
module tb_ula_resultado_bcd;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  resultado = '0;
  logic        carry = 1'b0;
  logic [2:0]  opcode = '0;
  logic        ready;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic        negativo;
  logic        carry_q;

  int n_cmp = 0;
  int n_err = 0;

  ula_resultado_bcd dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .resultado (resultado),
    .carry     (carry),
    .opcode    (opcode),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .bcd       (bcd),
    .negativo  (negativo),
    .carry_q   (carry_q)
  );

  always #5 clock = ~clock;

  // {negativo, hundreds, tens, units} from plain decimal arithmetic
  function automatic logic [12:0] model(input logic [7:0] r,
                                        input logic [2:0] op);
    int m;
    logic n;
    n = (op == 3'b001) && (int'(r) > 127);
    m = n ? 256 - int'(r) : int'(r);
    return {n, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Issues one request; lat = cycles from acceptance to done, -1 on timeout
  task automatic run_conv(input logic [7:0] r, input logic [2:0] op,
                          input logic cy, output int lat);
    logic ok;
    lat = -1;
    wait_ready(ok);
    if (!ok) return;
    resultado = r;
    opcode    = op;
    carry     = cy;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    resultado = 8'($urandom);
    opcode    = 3'($urandom);
    carry     = 1'($urandom);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_cmp++;
    if ({ready, busy, done, negativo, carry_q, bcd} !== {5'b10000, 12'h000}) begin
      n_err++;
      $display("FAIL reset: got r%b b%b d%b n%b c%b bcd=%h, need 1 0 0 0 0 000",
               ready, busy, done, negativo, carry_q, bcd);
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    run_conv(8'd30, 3'b000, 1'b0, lat);
    n_cmp++;
    if (lat !== 8) begin
      n_err++;
      $display("FAIL basic_latency: got %0d need 8", lat);
    end
    n_cmp++;
    if ({negativo, bcd} !== {1'b0, 12'h030}) begin
      n_err++;
      $display("FAIL basic_value: got n%b %h need n0 030", negativo, bcd);
    end
  endtask

  task automatic test_hold();
    logic ok;
    int   bad = 0;
    int   seen = 0;
    wait_ready(ok);
    resultado = 8'd225;
    opcode    = 3'b010;
    carry     = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (bcd !== 12'h030) bad++;
      tick();
      if (done) seen = c;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL hold_old: %0d cycles showed %h, need 030 held", bad, bcd);
    end
    n_cmp++;
    if (seen !== 8 || {negativo, bcd} !== {1'b0, 12'h225}) begin
      n_err++;
      $display("FAIL mul_225: done@%0d n%b %h need done@8 n0 225",
               seen, negativo, bcd);
    end
  endtask

  task automatic test_sub();
    int lat;
    run_conv(8'hFE, 3'b001, 1'b0, lat);
    n_cmp++;
    if (lat !== 8 || {negativo, bcd} !== {1'b1, 12'h002}) begin
      n_err++;
      $display("FAIL sub_FE: lat %0d n%b %h need 8 n1 002", lat, negativo, bcd);
    end
    run_conv(8'h80, 3'b001, 1'b0, lat);
    n_cmp++;
    if ({negativo, bcd} !== {1'b1, 12'h128}) begin
      n_err++;
      $display("FAIL sub_80: got n%b %h need n1 128", negativo, bcd);
    end
    run_conv(8'h00, 3'b001, 1'b1, lat);
    n_cmp++;
    if ({negativo, bcd, carry_q} !== {1'b0, 12'h000, 1'b1}) begin
      n_err++;
      $display("FAIL sub_zero: got n%b %h c%b need n0 000 c1",
               negativo, bcd, carry_q);
    end
  endtask

  task automatic test_carry();
    int lat;
    run_conv(8'hFF, 3'b011, 1'b1, lat);
    n_cmp++;
    if ({negativo, bcd, carry_q} !== {1'b0, 12'h255, 1'b1}) begin
      n_err++;
      $display("FAIL op3_FF: got n%b %h c%b need n0 255 c1",
               negativo, bcd, carry_q);
    end
    run_conv(8'hFF, 3'b000, 1'b0, lat);
    n_cmp++;
    if (carry_q !== 1'b0) begin
      n_err++;
      $display("FAIL carry_clear: got %b need 0", carry_q);
    end
  endtask

  task automatic test_back_to_back();
    logic        ok;
    logic [7:0]  r1;
    logic [7:0]  r2;
    logic [12:0] v1 = '0;
    logic [12:0] v2 = '0;
    int          d1 = -1;
    int          d2 = -1;
    int          ndone = 0;
    logic        rdy9 = 1'b0;
    logic        bsy10 = 1'b0;
    r1 = 8'd77;
    r2 = 8'd199;
    wait_ready(ok);
    resultado = r1;
    opcode    = 3'b000;
    start     = 1'b1;
    tick();
    resultado = r2;
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (c == 9)  rdy9  = ready;
      if (c == 10) bsy10 = busy;
      if (c == 19) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin d1 = c; v1 = {negativo, bcd}; end
        if (ndone == 2) begin d2 = c; v2 = {negativo, bcd}; end
      end
    end
    n_cmp++;
    if (ndone !== 2 || d1 !== 8 || d2 !== 18) begin
      n_err++;
      $display("FAIL b2b_dones: %0d dones at %0d,%0d need 2 at 8,18",
               ndone, d1, d2);
    end
    n_cmp++;
    if (rdy9 !== 1'b1 || bsy10 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: ready@9=%b busy@10=%b need 1 1", rdy9, bsy10);
    end
    n_cmp++;
    if (v1 !== model(r1, 3'b000) || v2 !== model(r2, 3'b000)) begin
      n_err++;
      $display("FAIL b2b_values: got %h %h need %h %h",
               v1, v2, model(r1, 3'b000), model(r2, 3'b000));
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    int   late = 0;
    wait_ready(ok);
    resultado = 8'd143;
    opcode    = 3'b000;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bcd, ready, busy, done} !== {12'h000, 3'b100}) begin
      n_err++;
      $display("FAIL reset_mid: bcd %h r%b b%b d%b need 000 1 0 0",
               bcd, ready, busy, done);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done) late++;
    end
    n_cmp++;
    if (late != 0 || bcd !== 12'h000) begin
      n_err++;
      $display("FAIL reset_no_done: %0d dones bcd %h need 0 000", late, bcd);
    end
  endtask

  task automatic test_random();
    int          lat;
    logic [7:0]  r;
    logic [2:0]  op;
    logic        cy;
    logic [12:0] exp_v;
    for (int i = 0; i < 40; i++) begin
      r  = 8'($urandom);
      op = (i % 3 == 0) ? 3'b001 : 3'($urandom);
      cy = 1'($urandom);
      exp_v = model(r, op);
      run_conv(r, op, cy, lat);
      n_cmp++;
      if (lat !== 8 || {negativo, bcd} !== exp_v || carry_q !== cy) begin
        n_err++;
        $display("FAIL rand_%0d: r=%h op=%b lat %0d got %h c%b need 8 %h c%b",
                 i, r, op, lat, {negativo, bcd}, carry_q, exp_v, cy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_sub();
    test_carry();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
